// File: rtl/mdu_pkg.sv
// Shared types and ALU op codes for the multiply/divide sequencer.
// Imported by the EX-stage MDU files and its bench.
package mdu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_UNDEF = 4'hf;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One shift-add / restoring-divide iteration around the shared ALU.
// Purely combinational; the sequencer registers the result.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] opnd,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] nhi,
  output logic [W-1:0] nlo,
  output logic [W-1:0] lval,
  output logic [W-1:0] rval,
  output logic [3:0]   op
);

  logic [W-1:0] s;
  logic         c;
  logic         t;
  logic [W-1:0] h;
  logic [W-1:0] l;
  logic         borrow;

  always_comb begin
    s      = hi;
    c      = 1'b0;
    t      = hi[W-1];
    h      = {hi[W-2:0], lo[W-1]};
    l      = {lo[W-2:0], 1'b0};
    borrow = 1'b0;
    nhi    = hi;
    nlo    = lo;
    lval   = hi;
    rval   = opnd;
    op     = ALU_ADD;
    if (div) begin
      lval   = h;
      op     = ALU_SUB;
      borrow = alu_result > h;
      if (t | ~borrow) begin
        nhi = alu_result;
        nlo = {l[W-1:1], 1'b1};
      end else begin
        nhi = h;
        nlo = {l[W-1:1], 1'b0};
      end
    end else begin
      // carry of HI+M recovered locally; the ALU has no carry out
      if (lo[0]) begin
        s = alu_result;
        c = alu_result < hi;
      end
      nhi = {c, s[W-1:1]};
      nlo = {s[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// MULTU/DIVU sequencer: 32 iterations on the shared ALU, owns HI/LO.
// Holds busy (stall) and alu_grant while an operation is in flight.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_div,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wr_val,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_lvalue,
  output logic [DATA_W-1:0] alu_rvalue,
  output logic [3:0]        alu_op,
  output logic              alu_grant,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  mdu_state_t        state_q;
  mdu_state_t        state_d;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] nhi;
  logic [DATA_W-1:0] nlo;
  logic [DATA_W-1:0] lval;
  logic [DATA_W-1:0] rval;
  logic [3:0]        sop;
  logic              last;

  assign last = cnt == LAST;

  mdu_step #(.W(DATA_W)) u_step (
    .div        (state_q == MDU_DIV),
    .hi         (hi),
    .lo         (lo),
    .opnd       (opnd),
    .alu_result (alu_result),
    .nhi        (nhi),
    .nlo        (nlo),
    .lval       (lval),
    .rval       (rval),
    .op         (sop)
  );

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    alu_grant  = 1'b0;
    alu_lvalue = '0;
    alu_rvalue = '0;
    alu_op     = ALU_UNDEF;
    unique case (state_q)
      MDU_IDLE: begin
        if (start)
          state_d = op_div ? MDU_DIV : MDU_MUL;
      end
      MDU_MUL, MDU_DIV: begin
        busy       = 1'b1;
        alu_grant  = 1'b1;
        alu_lvalue = lval;
        alu_rvalue = rval;
        alu_op     = sop;
        if (last)
          state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt     <= '0;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= busy && last;
      if (busy) begin
        hi  <= nhi;
        lo  <= nlo;
        cnt <= cnt + 1'b1;
      end else if (start) begin
        cnt  <= '0;
        hi   <= '0;
        opnd <= op_div ? rt_val : rs_val;
        lo   <= op_div ? rs_val : rt_val;
      end else begin
        if (hi_we) hi <= wr_val;
        if (lo_we) lo <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer against an arithmetic model.
// The shared ALU is modelled here as plain add/sub.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        op_div = 0;
  logic [31:0] rs_val = 0;
  logic [31:0] rt_val = 0;
  logic        hi_we = 0;
  logic        lo_we = 0;
  logic [31:0] wr_val = 0;
  logic [31:0] alu_result;
  logic [31:0] alu_lvalue;
  logic [31:0] alu_rvalue;
  logic [3:0]  alu_op;
  logic        alu_grant;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    if (alu_op == ALU_ADD) alu_result = alu_lvalue + alu_rvalue;
    else if (alu_op == ALU_SUB) alu_result = alu_lvalue - alu_rvalue;
  end

  mdu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_div     (op_div),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wr_val     (wr_val),
    .alu_result (alu_result),
    .alu_lvalue (alu_lvalue),
    .alu_rvalue (alu_rvalue),
    .alu_op     (alu_op),
    .alu_grant  (alu_grant),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic d,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    if (!d) begin
      p = 64'(a) * 64'(b);
      return p;
    end
    if (b == 0) return {a, 32'hffffffff};
    return {a % b, a / b};
  endfunction

  // launch one op and wait out busy; ends at the negedge after busy drops
  task automatic run_op(input logic d, input logic [31:0] a,
                        input logic [31:0] b, output int cyc,
                        output bit ok);
    @(negedge clk);
    start = 1; op_div = d; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 0; rs_val = $urandom; rt_val = $urandom;
    cyc = 0; ok = 1;
    while (busy && cyc < 100) begin
      if (!alu_grant || done) ok = 0;
      if (alu_op != (d ? ALU_SUB : ALU_ADD)) ok = 0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic full_op(input string nm, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int cyc;
    bit ok;
    run_op(d, a, b, cyc, ok);
    chk({nm, " cycles"}, 64'(cyc), 64'd32);
    chk({nm, " ctl"}, 64'(ok), 64'd1);
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " hilo"}, {hi, lo}, exp);
    @(negedge clk);
    chk({nm, " done1"}, 64'(done), 64'd0);
  endtask

  vec_t vt[5];

  initial begin
    int cyc;
    int ndone;
    logic d;
    logic [31:0] a, b;

    vt[0] = '{0, 32'd3, 32'd5, 32'h0, 32'hf};
    vt[1] = '{0, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h1};
    vt[2] = '{1, 32'd100, 32'd7, 32'd2, 32'd14};
    vt[3] = '{1, 32'h80000000, 32'd3, 32'd2, 32'h2aaaaaaa};
    vt[4] = '{1, 32'h1234, 32'd0, 32'h1234, 32'hffffffff};

    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 0);
    chk("rst grant", 64'(alu_grant), 0);
    chk("rst done", 64'(done), 0);
    chk("rst hilo", {hi, lo}, 0);
    chk("rst aluop", 64'(alu_op), 64'(ALU_UNDEF));
    rst_n = 1;

    for (int i = 0; i < 5; i++)
      full_op($sformatf("vec%0d", i), vt[i].d, vt[i].a, vt[i].b,
              {vt[i].ehi, vt[i].elo});

    for (int i = 0; i < 20; i++) begin
      d = 1'($urandom);
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (d && i % 5 == 0) b = $urandom >> $urandom_range(0, 31);
      full_op($sformatf("rnd%0d", i), d, a, b, model(d, a, b));
    end

    // second start mid-flight must be ignored
    @(negedge clk);
    start = 1; op_div = 0; rs_val = 7; rt_val = 9;
    @(negedge clk);
    start = 0;
    ndone = 0;
    for (int c = 1; c < 45; c++) begin
      if (c == 5 || c == 20) begin
        start = 1; op_div = 1; rs_val = 32'd1000; rt_val = 32'd3;
      end else start = 0;
      if (done) ndone++;
      @(negedge clk);
    end
    chk("restart lo", {hi, lo}, 64'd63);
    chk("restart done", 64'(ndone), 64'd1);

    hi_we = 1; wr_val = 32'hdeadbeef;
    @(negedge clk);
    hi_we = 0;
    chk("mthi", 64'(hi), 64'hdeadbeef);
    lo_we = 1; wr_val = 32'h0badf00d;
    @(negedge clk);
    lo_we = 0;
    chk("mtlo", {hi, lo}, 64'hdeadbeef_0badf00d);

    // start wins over a simultaneous MTHI
    hi_we = 1; wr_val = 32'h55555555;
    full_op("start_wins", 0, 32'd6, 32'd7, 64'd42);
    hi_we = 0;

    // reset mid-divide aborts without done
    @(negedge clk);
    start = 1; op_div = 1; rs_val = 32'd999; rt_val = 32'd4;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort busy", 64'(busy), 0);
    chk("abort hilo", {hi, lo}, 0);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("abort quiet", 64'(ndone), 0);
    full_op("post_rst", 0, 32'd2, 32'd2, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
